// File: rtl/mem_arb_pkg.sv
// Shared types for the data-memory port arbiter.
// Requester ids, FSM states, bus direction constants and a round-robin helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACCESS,
        ARB_WAIT,
        ARB_RESP
    } arb_state_t;

    typedef enum logic [1:0] {
        REQ_IF,
        REQ_LD,
        REQ_ST
    } req_id_t;

    localparam logic MEM_READ  = 1'b1;
    localparam logic MEM_WRITE = 1'b0;

    // Requester id k steps after base in the ring fetch->load->store->fetch.
    function automatic logic [1:0] rr_slot(input logic [1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s > 2) s = s - 3;
        return 2'(s);
    endfunction

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational winner select for the memory port arbiter.
// Ports: req_i (bit = req_id_t), ptr_i (RR start) or starve_i (fixed mode), gnt_vld_o, gnt_id_o.
// Build option MEM_ARB_RR_EN selects round-robin; otherwise fixed priority with anti-starvation.
module mem_arb_picker
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
`ifdef MEM_ARB_RR_EN
    input  logic [1:0] ptr_i,
`else
    input  logic [3:0] starve_i,
`endif
    input  logic [2:0] req_i,
    output logic       gnt_vld_o,
    output logic [1:0] gnt_id_o
);

`ifdef MEM_ARB_RR_EN
    // Scan from the far end so the slot nearest the pointer wins.
    always_comb begin
        gnt_vld_o = |req_i;
        gnt_id_o  = REQ_IF;
        for (int k = 2; k >= 0; k--) begin
            if (req_i[rr_slot(ptr_i, k)]) gnt_id_o = rr_slot(ptr_i, k);
        end
    end
`else
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    always_comb begin
        gnt_vld_o = |req_i;
        gnt_id_o  = REQ_IF;
        if (starve_i == STARVE_LIM && req_i[REQ_IF]) begin
            gnt_id_o = REQ_IF;
        end else if (req_i[REQ_ST]) begin
            gnt_id_o = REQ_ST;
        end else if (req_i[REQ_LD]) begin
            gnt_id_o = REQ_LD;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port among fetch (read), load (read) and store (write).
// Each access runs IDLE->ACCESS->[WAIT x RD_LAT]->RESP; RESP pulses the winner's ack.
// Ports: i_clk, i_rst (async active-low); i_if_*/o_if_* fetch; i_ld_*/o_ld_* load;
//   i_st_*/o_st_ack store; o_mem_* / i_mem_read_data memory side; o_busy = not IDLE.
// Build option MEM_ARB_RR_EN: round-robin arbitration instead of fixed priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic        o_if_ack,
    output logic [31:0] o_if_rdata,
    input  logic        i_ld_req,
    input  logic [31:0] i_ld_addr,
    input  logic [3:0]  i_ld_byte_en,
    output logic        o_ld_ack,
    output logic [31:0] o_ld_rdata,
    input  logic        i_st_req,
    input  logic [31:0] i_st_addr,
    input  logic [31:0] i_st_wdata,
    input  logic [3:0]  i_st_byte_en,
    output logic        o_st_ack,
    output logic        o_mem_rw_mode,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_write_data,
    output logic [3:0]  o_mem_byte_en,
    input  logic [31:0] i_mem_read_data,
    output logic        o_busy
);

    arb_state_t  state_q, state_d;
    req_id_t     id_q, id_d;
    logic        rw_q, rw_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  wcnt_q, wcnt_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] ld_rdata_q, ld_rdata_d;

    logic [2:0]  req_vec;
    logic        gnt_vld;
    logic [1:0]  gnt_id;
    logic        mem_act;

    assign req_vec = {i_st_req, i_ld_req, i_if_req};

`ifdef MEM_ARB_RR_EN
    logic [1:0] ptr_q, ptr_d;

    mem_arb_picker #(.STARVE_MAX(STARVE_MAX)) u_pick (
        .ptr_i     (ptr_q),
        .req_i     (req_vec),
        .gnt_vld_o (gnt_vld),
        .gnt_id_o  (gnt_id)
    );

    // Pointer names the first slot searched at the next grant.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == ARB_IDLE && gnt_vld) ptr_d = rr_slot(gnt_id, 1);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) ptr_q <= REQ_IF;
        else        ptr_q <= ptr_d;
    end
`else
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_q, starve_d;

    mem_arb_picker #(.STARVE_MAX(STARVE_MAX)) u_pick (
        .starve_i  (starve_q),
        .req_i     (req_vec),
        .gnt_vld_o (gnt_vld),
        .gnt_id_o  (gnt_id)
    );

    // Counts grants that bypassed a waiting fetch.
    always_comb begin
        starve_d = starve_q;
        if (state_q == ARB_IDLE) begin
            if (!i_if_req) begin
                starve_d = '0;
            end else if (gnt_id == REQ_IF) begin
                starve_d = '0;
            end else if (starve_q != STARVE_LIM) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) starve_q <= '0;
        else        starve_q <= starve_d;
    end
`endif

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        wcnt_d     = wcnt_q;
        if_rdata_d = if_rdata_q;
        ld_rdata_d = ld_rdata_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (gnt_vld) begin
                    state_d = ARB_ACCESS;
                    id_d    = req_id_t'(gnt_id);
                    unique case (gnt_id)
                        REQ_ST: begin
                            rw_d    = MEM_WRITE;
                            addr_d  = i_st_addr;
                            wdata_d = i_st_wdata;
                            be_d    = i_st_byte_en;
                        end
                        REQ_LD: begin
                            rw_d    = MEM_READ;
                            addr_d  = i_ld_addr;
                            wdata_d = '0;
                            be_d    = i_ld_byte_en;
                        end
                        default: begin
                            rw_d    = MEM_READ;
                            addr_d  = i_if_addr;
                            wdata_d = '0;
                            be_d    = 4'b1111;
                        end
                    endcase
                end
            end
            ARB_ACCESS: begin
                if (rw_q == MEM_READ) begin
                    state_d = ARB_WAIT;
                    wcnt_d  = 3'(RD_LAT - 1);
                end else begin
                    state_d = ARB_RESP;
                end
            end
            ARB_WAIT: begin
                if (wcnt_q == '0) begin
                    state_d = ARB_RESP;
                    if (id_q == REQ_IF) if_rdata_d = i_mem_read_data;
                    if (id_q == REQ_LD) ld_rdata_d = i_mem_read_data;
                end else begin
                    wcnt_d = wcnt_q - 3'd1;
                end
            end
            ARB_RESP: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= ARB_IDLE;
            id_q       <= REQ_IF;
            rw_q       <= MEM_READ;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            wcnt_q     <= '0;
            if_rdata_q <= '0;
            ld_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            wcnt_q     <= wcnt_d;
            if_rdata_q <= if_rdata_d;
            ld_rdata_q <= ld_rdata_d;
        end
    end

    // Bus shows the latched access only while it is in flight.
    assign mem_act          = (state_q == ARB_ACCESS) || (state_q == ARB_WAIT);
    assign o_mem_rw_mode    = mem_act ? rw_q    : MEM_READ;
    assign o_mem_addr       = mem_act ? addr_q  : '0;
    assign o_mem_write_data = mem_act ? wdata_q : '0;
    assign o_mem_byte_en    = mem_act ? be_q    : '0;

    assign o_if_ack   = (state_q == ARB_RESP) && (id_q == REQ_IF);
    assign o_ld_ack   = (state_q == ARB_RESP) && (id_q == REQ_LD);
    assign o_st_ack   = (state_q == ARB_RESP) && (id_q == REQ_ST);
    assign o_if_rdata = if_rdata_q;
    assign o_ld_rdata = ld_rdata_q;
    assign o_busy     = (state_q != ARB_IDLE);

endmodule
